// File: rtl/process_scheduler.sv
// Round-robin preemptive process scheduler: tracks ready slots and saved PCs,
// counts retired instructions against a quantum and sequences context switches.
module process_scheduler #(
  parameter int NUM_PROCS   = 4,
  parameter int IDX_W       = 2,
  parameter int PC_W        = 10,
  parameter int QUANTUM_RST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tick,
  input  logic                 quantum_load,
  input  logic [15:0]          quantum_in,
  input  logic                 proc_create,
  input  logic [IDX_W-1:0]     create_idx,
  input  logic [PC_W-1:0]      create_pc,
  input  logic                 proc_exit,
  input  logic [PC_W-1:0]      cur_pc,
  input  logic                 switch_ack,
  output logic [IDX_W-1:0]     proc_index,
  output logic [PC_W-1:0]      restore_pc,
  output logic                 pc_load,
  output logic                 switch_req,
  output logic [NUM_PROCS-1:0] ready_mask,
  output logic                 idle
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SAVE    = 3'd1,
    S_SELECT  = 3'd2,
    S_RESTORE = 3'd3,
    S_IDLE    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_PROCS-1:0] ready_q, ready_d;
  logic [PC_W-1:0]      pc_tab_q [NUM_PROCS];
  logic [PC_W-1:0]      pc_tab_d [NUM_PROCS];
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PC_W-1:0]      rpc_q, rpc_d;
  logic [15:0]          quant_q, quant_d;
  logic [15:0]          count_q, count_d;
  logic                 exit_q, exit_d;
  logic                 pc_load_q, switch_req_q, idle_q;
  logic [IDX_W-1:0]     sel_s;
  logic                 found_s;
  logic                 create_ok_s;

  // Round-robin search starting after the running slot; the running slot itself is tried last.
  always_comb begin
    sel_s   = idx_q;
    found_s = 1'b0;
    for (int i = 1; i <= NUM_PROCS; i++) begin
      if (!found_s && ready_q[idx_q + IDX_W'(i)]) begin
        sel_s   = idx_q + IDX_W'(i);
        found_s = 1'b1;
      end else begin
        sel_s   = sel_s;
      end
    end
  end

  // Next-state logic: create is applied first so a same-cycle save or exit overrides it.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    pc_tab_d = pc_tab_q;
    idx_d    = idx_q;
    rpc_d    = rpc_q;
    quant_d  = quant_q;
    count_d  = count_q;
    exit_d   = exit_q;

    create_ok_s = proc_create && !(state_q == S_RUN && create_idx == idx_q);
    if (create_ok_s) begin
      ready_d[create_idx]  = 1'b1;
      pc_tab_d[create_idx] = create_pc;
    end else begin
      ready_d = ready_d;
    end

    if (quantum_load) begin
      quant_d = (quantum_in == 16'd0) ? 16'd1 : quantum_in;
    end else begin
      quant_d = quant_q;
    end

    case (state_q)
      S_RUN: begin
        if (enable && tick) begin
          count_d = count_q - 16'd1;
        end else begin
          count_d = count_q;
        end
        if (proc_exit) begin
          state_d = S_SAVE;
          exit_d  = 1'b1;
        end else if (enable && tick && count_q == 16'd1) begin
          state_d = S_SAVE;
          exit_d  = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_SAVE: begin
        if (switch_ack) begin
          if (exit_q) begin
            ready_d[idx_q] = 1'b0;
          end else begin
            pc_tab_d[idx_q] = cur_pc;
          end
          state_d = S_SELECT;
        end else begin
          state_d = S_SAVE;
        end
      end
      S_SELECT: begin
        if (found_s) begin
          state_d = S_RESTORE;
          idx_d   = sel_s;
          rpc_d   = pc_tab_d[sel_s];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESTORE: begin
        count_d = quant_q;
        state_d = S_RUN;
      end
      S_IDLE: begin
        if ((|ready_q) || proc_create) begin
          state_d = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      ready_q      <= {{(NUM_PROCS-1){1'b0}}, 1'b1};
      for (int i = 0; i < NUM_PROCS; i++) begin
        pc_tab_q[i] <= '0;
      end
      idx_q        <= '0;
      rpc_q        <= '0;
      quant_q      <= 16'(QUANTUM_RST);
      count_q      <= 16'(QUANTUM_RST);
      exit_q       <= 1'b0;
      pc_load_q    <= 1'b0;
      switch_req_q <= 1'b0;
      idle_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      pc_tab_q     <= pc_tab_d;
      idx_q        <= idx_d;
      rpc_q        <= rpc_d;
      quant_q      <= quant_d;
      count_q      <= count_d;
      exit_q       <= exit_d;
      pc_load_q    <= (state_d == S_RESTORE);
      switch_req_q <= (state_d == S_SAVE);
      idle_q       <= (state_d == S_IDLE);
    end
  end

  assign proc_index = idx_q;
  assign restore_pc = rpc_q;
  assign pc_load    = pc_load_q;
  assign switch_req = switch_req_q;
  assign ready_mask = ready_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Self-checking bench for process_scheduler: directed vector table, hand-written
// switch sequences, and random traffic checked against a behavioural model.
module tb_process_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, tick, quantum_load, proc_create, proc_exit, switch_ack;
  logic [15:0] quantum_in;
  logic [1:0]  create_idx;
  logic [9:0]  create_pc, cur_pc;
  logic [1:0]  proc_index;
  logic [9:0]  restore_pc;
  logic        pc_load, switch_req, idle;
  logic [3:0]  ready_mask;

  int total = 0;
  int bad   = 0;

  process_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick),
    .quantum_load(quantum_load), .quantum_in(quantum_in),
    .proc_create(proc_create), .create_idx(create_idx), .create_pc(create_pc),
    .proc_exit(proc_exit), .cur_pc(cur_pc), .switch_ack(switch_ack),
    .proc_index(proc_index), .restore_pc(restore_pc), .pc_load(pc_load),
    .switch_req(switch_req), .ready_mask(ready_mask), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int rst, tk, ex, ack, cr, cidx, cpc, cur, ql, qin;
    int e_idx, e_req, e_load, e_idle, e_mask, e_rpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int rst, int tk, int ex, int ack, int cr, int cidx, int cpc,
                             int cur, int ql, int qin, int e_idx, int e_req, int e_load,
                             int e_idle, int e_mask, int e_rpc);
    vec_t r;
    r.rst = rst; r.tk = tk; r.ex = ex; r.ack = ack; r.cr = cr; r.cidx = cidx;
    r.cpc = cpc; r.cur = cur; r.ql = ql; r.qin = qin;
    r.e_idx = e_idx; r.e_req = e_req; r.e_load = e_load; r.e_idle = e_idle;
    r.e_mask = e_mask; r.e_rpc = e_rpc;
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_inputs();
    reset = 1'b0; enable = 1'b1; tick = 1'b0; quantum_load = 1'b0; quantum_in = 16'd0;
    proc_create = 1'b0; create_idx = 2'd0; create_pc = 10'd0; proc_exit = 1'b0;
    cur_pc = 10'd0; switch_ack = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Tick every cycle until switch_req rises; n = ticks applied, -1 on timeout.
  task automatic run_to_switch(output int n);
    n = -1;
    tick = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      cyc();
      if (switch_req === 1'b1) begin
        n = k;
        break;
      end
    end
    tick = 1'b0;
  endtask

  // Acknowledge a pending switch with the given PC, wait for pc_load, then step into RUN.
  task automatic do_switch(input int pcv, output int idx, output int rpc);
    idx = -1; rpc = -1;
    switch_ack = 1'b1; cur_pc = pcv[9:0];
    cyc();
    switch_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (pc_load === 1'b1) begin
        idx = int'(proc_index);
        rpc = int'(restore_pc);
        break;
      end
    end
    cyc();
  endtask

  // Behavioural model: phases 0 running, 1 awaiting ack, 2 choosing, 3 loading PC, 4 idle.
  int m_ph, m_run, m_rpc, m_left, m_quant;
  int m_pc[4];
  bit m_rdy[4];
  bit m_why_exit;

  task automatic mdl_step();
    bit old_rdy[4];
    bit any;
    int nph;
    if (reset) begin
      m_ph = 0; m_run = 0; m_rpc = 0; m_left = 16; m_quant = 16; m_why_exit = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_pc[k] = 0;
        m_rdy[k] = (k == 0);
      end
      return;
    end
    old_rdy = m_rdy;
    nph = m_ph;
    if (proc_create && !(m_ph == 0 && int'(create_idx) == m_run)) begin
      m_rdy[create_idx] = 1'b1;
      m_pc[create_idx]  = int'(create_pc);
    end
    case (m_ph)
      0: begin
        if (enable && tick) m_left = m_left - 1;
        if (proc_exit) begin
          nph = 1; m_why_exit = 1'b1;
        end else if (enable && tick && m_left == 0) begin
          nph = 1; m_why_exit = 1'b0;
        end
      end
      1: if (switch_ack) begin
        if (m_why_exit) m_rdy[m_run] = 1'b0;
        else m_pc[m_run] = int'(cur_pc);
        nph = 2;
      end
      2: begin
        nph = 4;
        for (int k = 1; k <= 4; k++) begin
          if (old_rdy[(m_run + k) % 4]) begin
            m_run = (m_run + k) % 4;
            m_rpc = m_pc[m_run];
            nph = 3;
            break;
          end
        end
      end
      3: begin
        m_left = m_quant;
        nph = 0;
      end
      default: begin
        any = 1'b0;
        for (int k = 0; k < 4; k++) any = any | old_rdy[k];
        if (any || proc_create) nph = 2;
      end
    endcase
    if (quantum_load) m_quant = (quantum_in == 16'd0) ? 1 : int'(quantum_in);
    m_ph = nph;
  endtask

  function automatic int m_mask();
    int r = 0;
    for (int k = 0; k < 4; k++) if (m_rdy[k]) r = r | (1 << k);
    return r;
  endfunction

  initial begin
    int n, idx, rpc, seen;
    int exp_idx[4];
    int exp_rpc[4];
    vec_t r;

    clear_inputs();

    // Directed vector table: one row per cycle, outputs checked after the edge.
    tbl.push_back(v(1,0,0,0,0,0,0,0,    0,0,  0,0,0,0,4'b0001,10'h000));
    tbl.push_back(v(0,0,0,0,1,1,'h40,0, 1,0,  0,0,0,0,4'b0011,10'h000));
    tbl.push_back(v(0,0,1,0,0,0,0,0,    0,0,  0,1,0,0,4'b0011,10'h000));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  0,1,0,0,4'b0011,10'h000));
    tbl.push_back(v(0,0,0,1,0,0,0,'h3FF,0,0,  0,0,0,0,4'b0010,10'h000));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  1,0,1,0,4'b0010,10'h040));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  1,0,0,0,4'b0010,10'h040));
    tbl.push_back(v(0,1,0,0,0,0,0,0,    0,0,  1,1,0,0,4'b0010,10'h040));
    tbl.push_back(v(0,0,0,1,0,0,0,'h123,0,0,  1,0,0,0,4'b0010,10'h040));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  1,0,1,0,4'b0010,10'h123));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  1,0,0,0,4'b0010,10'h123));
    tbl.push_back(v(0,0,1,0,0,0,0,0,    0,0,  1,1,0,0,4'b0010,10'h123));
    tbl.push_back(v(0,0,0,1,0,0,0,0,    0,0,  1,0,0,0,4'b0000,10'h123));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  1,0,0,1,4'b0000,10'h123));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  1,0,0,1,4'b0000,10'h123));
    tbl.push_back(v(0,0,0,0,1,3,'h10,0, 0,0,  1,0,0,0,4'b1000,10'h123));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  3,0,1,0,4'b1000,10'h010));
    tbl.push_back(v(0,0,0,0,0,0,0,0,    0,0,  3,0,0,0,4'b1000,10'h010));
    tbl.push_back(v(1,1,0,0,0,0,0,0,    0,0,  0,0,0,0,4'b0001,10'h000));

    foreach (tbl[i]) begin
      r = tbl[i];
      reset = r.rst[0]; tick = r.tk[0]; proc_exit = r.ex[0]; switch_ack = r.ack[0];
      proc_create = r.cr[0]; create_idx = r.cidx[1:0]; create_pc = r.cpc[9:0];
      cur_pc = r.cur[9:0]; quantum_load = r.ql[0]; quantum_in = r.qin[15:0]; enable = 1'b1;
      cyc();
      chk($sformatf("row%0d_idx", i),  int'(proc_index), r.e_idx);
      chk($sformatf("row%0d_req", i),  int'(switch_req), r.e_req);
      chk($sformatf("row%0d_load", i), int'(pc_load),    r.e_load);
      chk($sformatf("row%0d_idle", i), int'(idle),       r.e_idle);
      chk($sformatf("row%0d_mask", i), int'(ready_mask), r.e_mask);
      chk($sformatf("row%0d_rpc", i),  int'(restore_pc), r.e_rpc);
    end
    clear_inputs();

    // Quantum: first expiry uses the reset quantum, the next one the loaded value.
    do_reset();
    quantum_load = 1'b1; quantum_in = 16'd3;
    cyc();
    quantum_load = 1'b0;
    run_to_switch(n);
    chk("first_expiry_ticks", n, 16);
    do_switch('h2AA, idx, rpc);
    chk("self_reselect_idx", idx, 0);
    chk("self_reselect_rpc", rpc, 'h2AA);
    run_to_switch(n);
    chk("second_expiry_ticks", n, 3);

    // Held ack: request stays up, ticks ignored, quantum still stored.
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1; quantum_load = 1'b1; quantum_in = 16'd5;
      cyc();
      if (switch_req !== 1'b1 || pc_load !== 1'b0) seen++;
    end
    clear_inputs();
    chk("held_ack_req_no_load", seen, 0);
    do_switch('h155, idx, rpc);
    chk("held_ack_rpc", rpc, 'h155);
    run_to_switch(n);
    chk("stored_quantum_ticks", n, 5);
    do_switch('h0, idx, rpc);

    // Preemption disabled: fifty ticks must not raise a request.
    seen = 0;
    enable = 1'b0; tick = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (switch_req === 1'b1) seen++;
    end
    clear_inputs();
    chk("disabled_no_switch", seen, 0);

    // Round robin over three processes.
    do_reset();
    proc_create = 1'b1; create_idx = 2'd1; create_pc = 10'h040;
    cyc();
    create_idx = 2'd2; create_pc = 10'h080;
    cyc();
    proc_create = 1'b0;
    chk("rr_mask", int'(ready_mask), 4'b0111);
    exp_idx = '{1, 2, 0, 1};
    exp_rpc = '{'h040, 'h080, 'h100, 'h101};
    for (int k = 0; k < 4; k++) begin
      run_to_switch(n);
      do_switch('h100 + k, idx, rpc);
      chk($sformatf("rr%0d_idx", k), idx, exp_idx[k]);
      chk($sformatf("rr%0d_rpc", k), rpc, exp_rpc[k]);
    end

    // Reset while choosing and while awaiting ack.
    for (int w = 0; w < 2; w++) begin
      do_reset();
      proc_exit = 1'b1;
      cyc();
      proc_exit = 1'b0;
      if (w == 0) begin
        switch_ack = 1'b1;
        cyc();
        switch_ack = 1'b0;
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk($sformatf("rst%0d_outs", w),
          {int'(proc_index), int'(restore_pc), int'(pc_load), int'(switch_req), int'(idle)}, 0);
      chk($sformatf("rst%0d_mask", w), int'(ready_mask), 1);
      run_to_switch(n);
      chk($sformatf("rst%0d_expiry", w), n, 16);
    end

    // Random traffic against the behavioural model.
    clear_inputs();
    for (int c = 0; c < 3000; c++) begin
      reset        = (c == 0) || ($urandom_range(0, 299) == 0);
      enable       = ($urandom_range(0, 9) != 0);
      tick         = ($urandom_range(0, 9) < 7);
      quantum_load = ($urandom_range(0, 19) == 0);
      quantum_in   = 16'($urandom_range(0, 6));
      proc_create  = ($urandom_range(0, 11) == 0);
      create_idx   = 2'($urandom_range(0, 3));
      create_pc    = 10'($urandom);
      proc_exit    = ($urandom_range(0, 24) == 0);
      cur_pc       = 10'($urandom);
      switch_ack   = ($urandom_range(0, 9) < 4);
      mdl_step();
      cyc();
      total++;
      if (int'(proc_index) != m_run || int'(restore_pc) != m_rpc ||
          int'(pc_load) != int'(m_ph == 3) || int'(switch_req) != int'(m_ph == 1) ||
          int'(idle) != int'(m_ph == 4) || int'(ready_mask) != m_mask()) begin
        bad++;
        $display("FAIL rand_cycle%0d: got idx=%0d rpc=%0h load=%0b req=%0b idle=%0b mask=%0b expected idx=%0d rpc=%0h load=%0b req=%0b idle=%0b mask=%0b",
                 c, proc_index, restore_pc, pc_load, switch_req, idle, ready_mask,
                 m_run, m_rpc, (m_ph == 3), (m_ph == 1), (m_ph == 4), m_mask());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/process_scheduler.md
Name: process_scheduler

Overview:
Round-robin preemptive scheduler for the multiprogrammed core. It keeps a ready mask and a saved-PC table for up to NUM_PROCS processes, and counts retired instructions against a programmable quantum. On quantum expiry or process exit it requests a context switch, selects the next ready process, and drives the process index to the memory shifter and the restore PC to the program counter. Process 0 is the kernel/OS.

Parameters:
NUM_PROCS, 4, number of process slots (power of two).
IDX_W, 2, width of a process index (log2 NUM_PROCS).
PC_W, 10, program counter width.
QUANTUM_RST, 16, quantum value loaded at reset.

Ports:
clk  input  1  core clock (divided clock)
reset  input  1  synchronous, active-high reset
enable  input  1  preemption enable; quantum counter frozen when low
tick  input  1  one instruction retired this cycle
quantum_load  input  1  load quantum_in into the quantum register
quantum_in  input  16  new quantum, in instructions
proc_create  input  1  mark process create_idx ready, with start PC create_pc
create_idx  input  IDX_W  slot being created
create_pc  input  PC_W  start PC of the created process
proc_exit  input  1  running process terminated (hlt in user process)
cur_pc  input  PC_W  current PC, sampled at save
switch_ack  input  1  core has drained and accepted the switch request
proc_index  output  IDX_W  running process index, to the memory shifter
restore_pc  output  PC_W  PC to load on switch
pc_load  output  1  one-cycle strobe: load restore_pc into PC
switch_req  output  1  preemption interrupt request, level
ready_mask  output  NUM_PROCS  ready bit per slot
idle  output  1  no ready process

Behaviour:
- All state is updated on the rising edge of clk. Reset is synchronous.
- Reset values: ready_mask = 1 (only proc 0 ready). PC table all zero. proc_index = 0. Quantum register = QUANTUM_RST. Counter = QUANTUM_RST. State = RUN. switch_req = 0, pc_load = 0, idle = 0, restore_pc = 0.
- Quantum: quantum_load writes quantum_in. A value of 0 is stored as 1. The new value takes effect at the next counter reload; the running count is not affected.
- States:
  - RUN: If enable and tick, the counter decrements. If enable and tick with counter = 1, go to SAVE with reason = preempt. proc_exit goes to SAVE with reason = exit; exit has priority over expiry in the same cycle.
  - SAVE: switch_req = 1 and held until the cycle switch_ack = 1. In that cycle:
    - for preempt, store PC table[proc_index] = cur_pc;
    - for exit, clear ready_mask[proc_index] instead of saving.
    - Then go to SELECT.
  - SELECT: one cycle, switch_req = 0. Search slots proc_index+1, +2, … wrapping modulo NUM_PROCS, with proc_index itself checked last. The first ready slot wins.
    - If one is found, go to RESTORE.
    - If none, go to IDLE.
  - RESTORE: one cycle. proc_index = selected slot, restore_pc = PC table[slot], pc_load = 1, counter reloaded from the quantum register. Go to RUN.
  - IDLE: idle = 1, switch_req = 0. Stays until any ready bit becomes set (by create), then goes to SELECT. The search starts from proc_index+1.
- If the preempted process is the only ready one, it is reselected. A full save/restore still occurs, with restore_pc equal to the saved PC.
- proc_create is accepted in every state:
  - ready_mask[create_idx] = 1 and PC table[create_idx] = create_pc.
  - If create_idx equals the running index in RUN, it is ignored (neither mask nor PC changes).
- Create and exit in the same cycle on different slots: both are applied. On the same slot, exit wins.
- Create and the SAVE-ack write in the same cycle to the same PC slot: the save wins.
- tick is ignored outside RUN. enable low does not block exit.
- Latency: from the expiry tick, switch_req asserts 1 cycle later. From switch_ack, pc_load asserts 2 cycles later (SELECT, then RESTORE).
- Reset asserted in any state aborts the operation and returns to the reset values on that edge.

Test Plan:
- Reset, then quantum_load = 3, then 20 ticks with only proc 0 ready → first switch_req after tick 16 (QUANTUM_RST). Proc 0 is reselected with restore_pc = the cur_pc supplied. Next switch comes after 3 ticks.
- Create procs 1 (pc 0x40) and 2 (pc 0x80), run quanta with ack tied high → proc_index sequence 0,1,2,0,1. Each pc_load carries that slot's saved PC. ready_mask = 0111.
- proc_exit while proc 1 runs (mask 0011) → no save, mask becomes 0001, next proc_index = 0.
- Exit of the only ready process → idle = 1. Then create slot 3 with pc 0x10 → SELECT, then RESTORE with proc_index = 3, restore_pc = 0x10, idle = 0.
- Hold switch_ack low for 5 cycles in SAVE → switch_req stays high, no pc_load, and tick/quantum_load are ignored except for storing the quantum. With enable = 0 for 50 ticks, no switch_req occurs.
- Assert reset during SELECT and during SAVE → the next cycle shows all outputs at reset values, and a later expiry occurs after 16 ticks.
